accumulator_bank: RTL and testbench

Multi-channel, parametrised adder/accumulator.
- Accepts operands over a valid/ready handshake and adds each one into one of CHANNELS accumulators.
- Each channel keeps an add counter with a carry flag and a sticky overflow flag; overflow either wraps or saturates.
- On request, an FSM serialises one channel's count, flags and accumulator value as bytes over a handshaked byte port, optionally clearing the channel.
- Sits between the operand source and the byte-wide readout/host interface.

---
 rtl/accumulator_bank_pkg.sv | 19 +
 rtl/accumulator_lane.sv | 53 +++++
 rtl/accumulator_bank.sv | 156 +++++++++++++++
 tb/tb_accumulator_bank.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_bank_pkg.sv
// Shared types and constants for the accumulator bank.
package accumulator_bank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SEND
  } state_t;

  // Bit positions inside the dump flag byte.
  localparam int unsigned OVF_BIT    = 1;
  localparam int unsigned CCARRY_BIT = 0;

  // Bytes per dump: count, flags, then the accumulator.
  function automatic int unsigned dump_bytes(input int unsigned acc_width);
    return 2 + acc_width / 8;
  endfunction

endpackage

// File: rtl/accumulator_lane.sv
// One accumulator channel: acc, add counter and sticky carry/overflow flags.
module accumulator_lane
  import accumulator_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] add_data,
  input  logic                  sat_mode,
  input  logic                  clear,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic [7:0]            cnt,
  output logic                  ovf,
  output logic                  cnt_carry
);

  logic [ACC_WIDTH:0] sum;
  logic [8:0]         cnt_sum;

  // Widened sums so the carry out of each counter is visible.
  always_comb begin
    sum     = {1'b0, acc} + (ACC_WIDTH+1)'(add_data);
    cnt_sum = {1'b0, cnt} + 9'd1;
  end

  // Per-lane state: clear wins, otherwise a single-cycle read-modify-write add.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      cnt_carry <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      cnt_carry <= 1'b0;
    end else if (add_en) begin
      if (sum[ACC_WIDTH] && sat_mode) begin
        acc <= '1;
      end else begin
        acc <= sum[ACC_WIDTH-1:0];
      end
      ovf       <= ovf | sum[ACC_WIDTH];
      cnt       <= cnt_sum[7:0];
      cnt_carry <= cnt_carry | cnt_sum[8];
    end
  end

endmodule

// File: rtl/accumulator_bank.sv
// Multi-channel accumulator with a byte-serial dump port.
module accumulator_bank
  import accumulator_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned CHANNELS   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic [$clog2(CHANNELS)-1:0] in_chan,
  input  logic                        sat_mode,
  input  logic                        dump_req,
  input  logic [$clog2(CHANNELS)-1:0] dump_chan,
  input  logic                        dump_clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [7:0]                  out_data,
  output logic                        out_last,
  output logic                        busy
);

  localparam int unsigned CH_W      = $clog2(CHANNELS);
  localparam int unsigned NB        = dump_bytes(ACC_WIDTH);
  localparam int unsigned ACC_BYTES = ACC_WIDTH / 8;
  localparam int unsigned IDX_W     = $clog2(NB);

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CH_W-1:0]  lat_chan_q, lat_chan_d;
  logic             lat_clear_q, lat_clear_d;
  logic             clear_en;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [CH_W-1:0]       s1_chan;
  logic                  s1_sat;

  logic [ACC_WIDTH-1:0] acc_arr [CHANNELS];
  logic [7:0]           cnt_arr [CHANNELS];
  logic                 ovf_arr [CHANNELS];
  logic                 cc_arr  [CHANNELS];

  logic [ACC_WIDTH-1:0] sel_acc;
  logic [7:0]           sel_byte;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign out_last  = out_valid && (idx_q == IDX_W'(NB - 1));
  assign out_data  = out_valid ? sel_byte : '0;

  // Stage 1: register the accepted operand.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_chan  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= in_valid && in_ready;
      s1_data  <= in_data;
      s1_chan  <= in_chan;
      s1_sat   <= sat_mode;
    end
  end

  // Stage 2: one lane per channel.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    accumulator_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clock    (clock),
      .reset    (reset),
      .add_en   (s1_valid && (s1_chan == CH_W'(g))),
      .add_data (s1_data),
      .sat_mode (s1_sat),
      .clear    (clear_en && (lat_chan_q == CH_W'(g))),
      .acc      (acc_arr[g]),
      .cnt      (cnt_arr[g]),
      .ovf      (ovf_arr[g]),
      .cnt_carry(cc_arr[g])
    );
  end

  // Dump FSM state and latched request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lat_chan_q  <= '0;
      lat_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lat_chan_q  <= lat_chan_d;
      lat_clear_q <= lat_clear_d;
    end
  end

  // Next-state logic; the clear pulse fires on the edge taking the last byte.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_chan_d  = lat_chan_q;
    lat_clear_d = lat_clear_q;
    clear_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          lat_chan_d  = dump_chan;
          lat_clear_d = dump_clear;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == IDX_W'(NB - 1)) begin
            state_d  = IDLE;
            clear_en = lat_clear_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte selection: count, flags, then accumulator MSB byte first.
  always_comb begin
    sel_acc  = acc_arr[lat_chan_q];
    sel_byte = '0;
    if (idx_q == '0) begin
      sel_byte = cnt_arr[lat_chan_q];
    end else if (idx_q == IDX_W'(1)) begin
      sel_byte[OVF_BIT]    = ovf_arr[lat_chan_q];
      sel_byte[CCARRY_BIT] = cc_arr[lat_chan_q];
    end else begin
      for (int unsigned k = 0; k < ACC_BYTES; k++) begin
        if (idx_q == IDX_W'(k + 2)) begin
          sel_byte = sel_acc[(ACC_BYTES-1-k)*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_accumulator_bank.sv
// Scoreboard bench for accumulator_bank with a behavioural channel model.
module tb_accumulator_bank;

  localparam int unsigned DW      = 8;
  localparam int unsigned AW      = 16;
  localparam int unsigned CH      = 4;
  localparam int unsigned AB      = AW / 8;
  localparam int unsigned NB      = 2 + AB;
  localparam int unsigned ACC_MAX = (1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_chan = '0;
  logic          sat_mode = 1'b0;
  logic          dump_req = 1'b0;
  logic [1:0]    dump_chan = '0;
  logic          dump_clear = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          out_last;
  logic          busy;

  accumulator_bank #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .CHANNELS  (CH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_chan   (in_chan),
    .sat_mode  (sat_mode),
    .dump_req  (dump_req),
    .dump_chan (dump_chan),
    .dump_clear(dump_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic per channel.
  int unsigned m_acc [CH];
  int unsigned m_cnt [CH];
  int unsigned m_ovf [CH];
  int unsigned m_cc  [CH];

  function automatic void model_zero(input int ch);
    m_acc[ch] = 0;
    m_cnt[ch] = 0;
    m_ovf[ch] = 0;
    m_cc[ch]  = 0;
  endfunction

  function automatic void model_add(input int ch, input int unsigned d, input bit sat);
    int unsigned s;
    s = m_acc[ch] + d;
    if (s > ACC_MAX) begin
      m_ovf[ch] = 1;
      m_acc[ch] = sat ? ACC_MAX : s - (ACC_MAX + 1);
    end else begin
      m_acc[ch] = s;
    end
    m_cnt[ch] = m_cnt[ch] + 1;
    if (m_cnt[ch] == 256) begin
      m_cnt[ch] = 0;
      m_cc[ch]  = 1;
    end
  endfunction

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t exp_q[$];

  function automatic void push_dump(input int ch);
    exp_t e;
    e.data = 8'(m_cnt[ch]);
    e.last = 1'b0;
    exp_q.push_back(e);
    e.data = 8'(m_ovf[ch] * 2 + m_cc[ch]);
    exp_q.push_back(e);
    for (int k = 0; k < int'(AB); k++) begin
      e.data = 8'(m_acc[ch] >> (8 * (int'(AB) - 1 - k)));
      e.last = (k == int'(AB) - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: compare every presented byte against the scoreboard head.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", out_data, $time);
        end else begin
          check("dump_byte", out_data, exp_q[0].data);
          check("dump_last", out_last, exp_q[0].last);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_op(input int ch, input int unsigned d, input bit sat);
    int n = 0;
    in_valid = 1'b1;
    in_chan  = 2'(ch);
    in_data  = 8'(d);
    sat_mode = sat;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("op_in_ready", in_ready, 1);
    if (in_ready) begin
      @(posedge clock); #1;
      model_add(ch, d, sat);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_dump(input int ch, input bit clr, input bit with_op, input int op_ch,
                         input int unsigned op_d, input int stall_byte, input int stall_cycles,
                         input int ignore_at, input int abort_at);
    int cycles = 0;
    int done = 0;
    int stall_left = stall_cycles;
    bit xfer;
    bit ign_sent = 1'b0;
    out_ready = 1'b1;
    check("idle_before_dump", busy, 0);
    dump_req   = 1'b1;
    dump_chan  = 2'(ch);
    dump_clear = clr;
    if (with_op) begin
      in_valid = 1'b1;
      in_chan  = 2'(op_ch);
      in_data  = 8'(op_d);
      sat_mode = 1'b0;
    end
    @(posedge clock); #1;
    dump_req = 1'b0;
    in_valid = 1'b0;
    if (with_op) model_add(op_ch, op_d, 1'b0);
    push_dump(ch);
    if (clr) model_zero(ch);
    check("drain_busy", busy, 1);
    check("drain_no_valid", out_valid, 0);
    while (done < int'(NB) && cycles < 300) begin
      if (abort_at >= 0 && done == abort_at && out_valid) begin
        exp_q.delete();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        for (int c = 0; c < int'(CH); c++) model_zero(c);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("ready_after_reset", in_ready, 1);
        return;
      end
      if (out_valid && done == stall_byte && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (ignore_at >= 0 && !ign_sent && out_valid && done == ignore_at) begin
        dump_req  = 1'b1;
        dump_chan = 2'(ch ^ 1);
        ign_sent  = 1'b1;
      end else begin
        dump_req = 1'b0;
      end
      check("busy_in_ready_low", in_ready, 0);
      xfer = out_valid && out_ready;
      @(posedge clock); #1;
      cycles++;
      if (xfer) done++;
    end
    dump_req  = 1'b0;
    out_ready = 1'b1;
    check("dump_cycles", cycles, NB + 1 + stall_cycles);
    check("idle_after_dump", busy, 0);
    check("ready_after_dump", in_ready, 1);
  endtask

  initial begin
    for (int c = 0; c < int'(CH); c++) model_zero(c);
    repeat (3) @(posedge clock);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("reset_in_ready", in_ready, 1);

    // Wrap-free small sum on ch0.
    send_op(0, 200, 1'b0);
    send_op(0, 100, 1'b0);
    do_dump(0, 1'b0, 1'b0, 0, 0, -1, 0, -1, -1);

    // Saturation on ch1, with count carry along the way.
    repeat (257) send_op(1, 255, 1'b0);
    send_op(1, 32, 1'b1);
    do_dump(1, 1'b0, 1'b0, 0, 0, -1, 0, -1, -1);

    // Count carry on ch2.
    repeat (256) send_op(2, 1, 1'b0);
    do_dump(2, 1'b0, 1'b0, 0, 0, -1, 0, -1, -1);

    // Wrapping overflow on ch3, then backpressured dump with clear and a re-dump.
    repeat (257) send_op(3, 255, 1'b0);
    send_op(3, 32, 1'b0);
    do_dump(3, 1'b1, 1'b0, 0, 0, 2, 3, -1, -1);
    do_dump(3, 1'b0, 1'b0, 0, 0, -1, 0, -1, -1);

    // Operand in the dump_req cycle, plus an ignored request during SEND.
    do_dump(0, 1'b0, 1'b1, 0, 5, -1, 0, 1, -1);

    // Reset during byte 1, then dumps read back zero.
    do_dump(1, 1'b0, 1'b0, 0, 0, -1, 0, -1, 1);
    do_dump(1, 1'b0, 1'b0, 0, 0, -1, 0, -1, -1);
    do_dump(0, 1'b0, 1'b0, 0, 0, -1, 0, -1, -1);

    // Randomized traffic.
    for (int r = 0; r < 10; r++) begin
      int n;
      n = int'($urandom_range(5, 30));
      for (int i = 0; i < n; i++) begin
        send_op(int'($urandom_range(0, CH - 1)), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      end
      do_dump(int'($urandom_range(0, CH - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, CH - 1)), $urandom_range(0, 255),
              int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1) ? 1 : -1, -1);
    end

    repeat (2) @(posedge clock);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
